// File: rtl/switch_arbiter.sv
// Two-requester round-robin arbiter feeding a nibble-swap / bit-reverse switch
// into a single-entry registered output stage, with per-transform counters.
module switch_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [7:0]       a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [7:0]       b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_src,
    output logic             out_mode,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [CNT_W-1:0] uni_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state;
    logic       last;
    logic       accept_en, grant_a, grant_b, accept, uniform;
    logic [7:0] sel, xf;

    assign accept_en = (state == EMPTY) | (out_valid & out_ready);

    // last = 1 means B went last, so A wins contention (and vice versa).
    assign grant_a = a_valid & (~b_valid | last);
    assign grant_b = b_valid & (~a_valid | ~last);
    assign a_ready = accept_en & grant_a;
    assign b_ready = accept_en & grant_b;
    assign accept  = a_ready | b_ready;

    assign sel     = grant_b ? b_data : a_data;
    assign uniform = (sel == 8'h00) | (sel == 8'hFF);

    always_comb begin
        xf = {sel[3:0], sel[7:4]};
        if (uniform) begin
            for (int k = 0; k < 8; k++) xf[k] = sel[7-k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_src   <= 1'b0;
            out_mode  <= 1'b0;
            last      <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state     <= FULL;
                    out_valid <= 1'b1;
                end
                FULL: if (out_ready && !accept) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
            if (accept) begin
                out_data <= xf;
                out_src  <= grant_b;
                out_mode <= ~uniform;
                last     <= grant_b;
            end
        end
    end

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_cnt <= '0;
            uni_cnt  <= '0;
        end else if (clr_cnt) begin
            swap_cnt <= '0;
            uni_cnt  <= '0;
        end else if (accept) begin
            if (uniform) uni_cnt  <= uni_cnt + CNT_W'(1);
            else         swap_cnt <= swap_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Round-robin scheduler that shares one nibble-swap/bit-reverse switch datapath between two byte requesters (A and B). Each requester presents bytes over a valid/ready handshake. The arbiter grants one byte per cycle, applies the switch transform, and holds the result in a single-entry registered output stage with its own valid/ready handshake. Per-mode statistics counters sit alongside for software observation.

## Interface

- CNT_W, 8, width of each statistics counter
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- a_valid  input  1  requester A has a byte
- a_data  input  8  requester A byte
- a_ready  output  1  A's byte is accepted this cycle
- b_valid  input  1  requester B has a byte
- b_data  input  8  requester B byte
- b_ready  output  1  B's byte is accepted this cycle
- out_valid  output  1  output register holds a result
- out_data  output  8  transformed byte
- out_src  output  1  source of out_data: 0 = A, 1 = B
- out_mode  output  1  1 = nibble swap applied, 0 = uniform byte (bit reverse)
- out_ready  input  1  consumer takes out_data this cycle
- clr_cnt  input  1  synchronous clear of both counters
- swap_cnt  output  CNT_W  accepted bytes transformed by nibble swap
- uni_cnt  output  CNT_W  accepted bytes transformed by bit reverse

## Operation

- Transform on the granted byte d:
  - If all 8 bits of d are equal (0x00 or 0xFF): out = bit-reverse of d, with out[k] = d[7-k], and mode = 0.
  - Otherwise: out = {d[3:0], d[7:4]} and mode = 1.
- Output FSM has two states, EMPTY and FULL.
  - accept_en = (state == EMPTY) | (out_valid & out_ready).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on out_ready with no accept.
  - FULL → FULL on out_ready with an accept in the same cycle. This is a back-to-back refill.
- Arbitration uses a 1-bit pointer `last` recording the last granted source.
  - If exactly one of a_valid/b_valid is high, that source is granted.
  - If both are high, the source other than `last` is granted.
  - `last` updates only on an accept.
- a_ready = accept_en & grant_A. b_ready = accept_en & grant_B. Both are combinational from the valids, state, out_ready and `last`. At most one is high in any cycle.
- An accept occurs when the granted source's valid and ready are both high. The output register then loads out_data, out_src and out_mode.
- While FULL and out_ready = 0, out_data, out_src and out_mode hold stable, and both readies are 0.
- Counters:
  - On an accept, the counter for the transform applied increments by 1, modulo 2^CNT_W (wraps, no saturation).
  - When clr_cnt = 1, both counters go to 0. clr_cnt takes precedence over a coincident increment.

## Timing

- Reset values (asynchronous, immediate on rst_n low):
  - state = EMPTY; out_valid = 0.
  - out_data = 0x00, out_src = 0, out_mode = 0.
  - swap_cnt = 0, uni_cnt = 0.
  - last = 1, so A wins the first contention.
- Latency is 1 cycle: a byte accepted at edge n appears on out_data with out_valid = 1 after edge n.
- Throughput is 1 byte per cycle while out_ready stays high.
- Reset asserted while FULL discards the held result. The first post-reset contention grants A.
- A requester may drop valid before it is granted. Nothing is recorded for it.
- Counter values update on the same edge as the accept and are visible the following cycle.

## Test plan

1. After reset, A presents 0xA5 alone with out_ready = 1 → a_ready = 1. Next cycle: out_valid = 1, out_data = 0x5A, out_src = 0, out_mode = 1, swap_cnt = 1.
2. B sends 0xFF, then 0x00 → out_data = 0xFF then 0x00, out_mode = 0, out_src = 1, uni_cnt = 2, swap_cnt unchanged.
3. A = 0x12 and B = 0x34 held valid continuously with out_ready = 1 → grants alternate A, B, A, B from the first cycle. out_data sequence is 0x21, 0x43, 0x21, 0x43 with out_src 0, 1, 0, 1.
4. Load 0xF0, then hold out_ready = 0 for 3 cycles with both requesters valid → out_data stays 0x0F and a_ready = b_ready = 0. Raise out_ready → 0x0F drains and the next byte is accepted in the same cycle, with out_valid staying 1.
5. With CNT_W = 2, send 5 swap bytes → swap_cnt = 1 (wrap). Assert clr_cnt in the same cycle as an accept → both counters are 0 the next cycle.
6. Drop rst_n mid-cycle while FULL holding 0x3C → out_valid = 0 and counters = 0 immediately, without waiting for a clock edge. After release with both requesters valid, A is granted first.
